// File: rtl/intersection_scheduler_if.sv
// Handshake/status bundle between the intersection scheduler and its environment.
// master drives the sensors and timing strobe; slave is the scheduler.
interface intersection_scheduler_if;
   logic       tick;
   logic       side_req;
   logic       ped_btn;
   logic [2:0] main_light;
   logic [2:0] side_light;
   logic       walk;
   logic [3:0] remaining;
   logic [2:0] phase;
   logic       ped_pending;

   modport master (
      output tick, side_req, ped_btn,
      input  main_light, side_light, walk, remaining, phase, ped_pending
   );

   modport slave (
      input  tick, side_req, ped_btn,
      output main_light, side_light, walk, remaining, phase, ped_pending
   );
endinterface

// File: rtl/intersection_scheduler.sv
// Phase scheduler for a main/side intersection with a pedestrian crossing.
// Outputs decode combinationally from the registered state, tick count and ped latch.
module intersection_scheduler #(
   parameter int unsigned T_MIN_GREEN = 4,
   parameter int unsigned T_MAX_GREEN = 9,
   parameter int unsigned T_YELLOW    = 3,
   parameter int unsigned T_CLEAR     = 2,
   parameter int unsigned T_WALK      = 5
) (
   input  logic                    clk,
   input  logic                    rst_n,
   intersection_scheduler_if.slave bus
);
   typedef enum logic [2:0] {
      INIT        = 3'd0,
      MAIN_GREEN  = 3'd1,
      MAIN_YELLOW = 3'd2,
      CLEAR_A     = 3'd3,
      SIDE_GREEN  = 3'd4,
      SIDE_YELLOW = 3'd5,
      WALK        = 3'd6,
      CLEAR_B     = 3'd7
   } state_t;

   localparam logic [3:0] MIN_M1 = 4'(T_MIN_GREEN - 1);

   state_t     state, state_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic [3:0] dur;
   logic       at_end;
   logic       ped_pending, ped_nxt;
   logic       last_served, last_nxt;

   // Length of the current phase; SIDE_GREEN uses its upper bound.
   always_comb begin
      dur = 4'(T_CLEAR);
      case (state)
         MAIN_YELLOW, SIDE_YELLOW: dur = 4'(T_YELLOW);
         SIDE_GREEN:               dur = 4'(T_MAX_GREEN);
         WALK:                     dur = 4'(T_WALK);
         default:                  dur = 4'(T_CLEAR);
      endcase
   end

   assign at_end = (cnt == dur - 4'd1);

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      if (bus.tick) begin
         cnt_nxt = cnt + 4'd1;
         case (state)
            INIT:        if (at_end) state_nxt = MAIN_GREEN;
            MAIN_GREEN: begin
               if (cnt >= MIN_M1) begin
                  cnt_nxt = MIN_M1;
                  if (bus.side_req || ped_pending) state_nxt = MAIN_YELLOW;
               end
            end
            MAIN_YELLOW: if (at_end) state_nxt = CLEAR_A;
            CLEAR_A: begin
               if (at_end) begin
                  if (bus.side_req && ped_pending)
                     state_nxt = last_served ? SIDE_GREEN : WALK;
                  else if (bus.side_req) state_nxt = SIDE_GREEN;
                  else if (ped_pending)  state_nxt = WALK;
                  else                   state_nxt = MAIN_GREEN;
               end
            end
            SIDE_GREEN:
               if (at_end || (cnt >= MIN_M1 && !bus.side_req)) state_nxt = SIDE_YELLOW;
            SIDE_YELLOW: if (at_end) state_nxt = CLEAR_B;
            WALK:        if (at_end) state_nxt = CLEAR_B;
            CLEAR_B:     if (at_end) state_nxt = MAIN_GREEN;
            default:     state_nxt = INIT;
         endcase
         if (state_nxt != state) cnt_nxt = '0;
      end
   end

   // Entering WALK clears the latch, overriding a press on the same cycle.
   always_comb begin
      ped_nxt  = ped_pending;
      last_nxt = last_served;
      if (bus.ped_btn && state != WALK) ped_nxt = 1'b1;
      if (state_nxt == WALK && state != WALK) begin
         ped_nxt  = 1'b0;
         last_nxt = 1'b1;
      end
      if (state_nxt == SIDE_GREEN && state != SIDE_GREEN) last_nxt = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= INIT;
         cnt         <= '0;
         ped_pending <= 1'b0;
         last_served <= 1'b1;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         ped_pending <= ped_nxt;
         last_served <= last_nxt;
      end
   end

   assign bus.phase       = state;
   assign bus.ped_pending = ped_pending;
   assign bus.walk        = (state == WALK);
   assign bus.remaining   = (state == MAIN_GREEN) ? 4'd0 : dur - cnt;
   assign bus.main_light  = (state == MAIN_GREEN)  ? 3'b100 :
                            (state == MAIN_YELLOW) ? 3'b010 : 3'b001;
   assign bus.side_light  = (state == SIDE_GREEN)  ? 3'b100 :
                            (state == SIDE_YELLOW) ? 3'b010 : 3'b001;
endmodule

// File: tb/tb_intersection_scheduler.sv
// Randomized bench for intersection_scheduler against a phase/elapsed-time model.
module tb_intersection_scheduler;
   localparam int T_MIN_GREEN = 4;
   localparam int T_MAX_GREEN = 9;
   localparam int T_YELLOW    = 3;
   localparam int T_CLEAR     = 2;
   localparam int T_WALK      = 5;

   localparam int P_INIT = 0, P_MG = 1, P_MY = 2, P_CA = 3;
   localparam int P_SG = 4, P_SY = 5, P_WK = 6, P_CB = 7;

   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_err;

   // Model: current phase, whole ticks spent in it, pedestrian latch, who was served last.
   int m_ph;
   int m_el;
   bit m_ped;
   bit m_last_ped;

   intersection_scheduler_if bus ();

   intersection_scheduler #(
      .T_MIN_GREEN(T_MIN_GREEN), .T_MAX_GREEN(T_MAX_GREEN), .T_YELLOW(T_YELLOW),
      .T_CLEAR(T_CLEAR), .T_WALK(T_WALK)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int dur_of(input int ph);
      case (ph)
         P_MY, P_SY: return T_YELLOW;
         P_SG:       return T_MAX_GREEN;
         P_WK:       return T_WALK;
         default:    return T_CLEAR;
      endcase
   endfunction

   function automatic int succ_of(input int ph);
      case (ph)
         P_INIT:  return P_MG;
         P_MY:    return P_CA;
         P_SY:    return P_CB;
         P_WK:    return P_CB;
         P_CB:    return P_MG;
         default: return ph;
      endcase
   endfunction

   task automatic model_reset();
      m_ph = P_INIT; m_el = 0; m_ped = 1'b0; m_last_ped = 1'b1;
   endtask

   task automatic model_step(input bit t, input bit s, input bit p);
      int nxt;
      bit done;
      bit ped_n;
      nxt = m_ph;
      if (t) begin
         done = (m_el + 1 >= dur_of(m_ph));
         case (m_ph)
            P_MG: if (m_el + 1 >= T_MIN_GREEN && (s || m_ped)) nxt = P_MY;
            P_SG: if (m_el + 1 >= T_MAX_GREEN || (m_el + 1 >= T_MIN_GREEN && !s)) nxt = P_SY;
            P_CA: if (done) begin
               if (s && m_ped)  nxt = m_last_ped ? P_SG : P_WK;
               else if (s)      nxt = P_SG;
               else if (m_ped)  nxt = P_WK;
               else             nxt = P_MG;
            end
            default: if (done) nxt = succ_of(m_ph);
         endcase
      end
      ped_n = m_ped;
      if (p && m_ph != P_WK) ped_n = 1'b1;
      if (nxt == P_WK && m_ph != P_WK) begin ped_n = 1'b0; m_last_ped = 1'b1; end
      if (nxt == P_SG && m_ph != P_SG) m_last_ped = 1'b0;
      m_ped = ped_n;
      if (nxt != m_ph) m_el = 0;
      else if (t)      m_el++;
      m_ph = nxt;
   endtask

   task automatic check_all();
      int exp_main, exp_side, exp_rem;
      exp_main = (m_ph == P_MG) ? 4 : (m_ph == P_MY) ? 2 : 1;
      exp_side = (m_ph == P_SG) ? 4 : (m_ph == P_SY) ? 2 : 1;
      exp_rem  = (m_ph == P_MG) ? 0 : dur_of(m_ph) - m_el;
      chk("phase", int'(bus.phase), m_ph);
      chk("main_light", int'(bus.main_light), exp_main);
      chk("side_light", int'(bus.side_light), exp_side);
      chk("walk", int'(bus.walk), (m_ph == P_WK) ? 1 : 0);
      chk("remaining", int'(bus.remaining), exp_rem);
      chk("ped_pending", int'(bus.ped_pending), int'(m_ped));
   endtask

   // Called at a negedge: drive, clock once, update model, check at the next negedge.
   task automatic cycle(input bit t, input bit s, input bit p);
      bus.tick = t; bus.side_req = s; bus.ped_btn = p;
      @(posedge clk);
      model_step(t, s, p);
      @(negedge clk);
      check_all();
   endtask

   function automatic bit rtick();
      return ($urandom_range(0, 2) != 0);
   endfunction

   initial begin
      bit side;
      bit hit;
      n_chk = 0; n_err = 0;
      rst_n = 1'b0;
      bus.tick = 1'b0; bus.side_req = 1'b0; bus.ped_btn = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      check_all();
      rst_n = 1'b1;

      // Idle: INIT then MAIN_GREEN held forever.
      for (int i = 0; i < 80; i++) cycle(1'b1, 1'b0, 1'b0);
      // Side road continuously present.
      for (int i = 0; i < 150; i++) cycle(rtick(), 1'b1, 1'b0);
      // Drain to MAIN_GREEN, one pedestrian pulse, presses during WALK.
      for (int i = 0; i < 40; i++) cycle(1'b1, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 60; i++) cycle(rtick(), 1'b0, (m_ph == P_WK) ? 1'b1 : 1'b0);
      // Both requesters always present: strict alternation.
      for (int i = 0; i < 250; i++) cycle(rtick(), 1'b1, 1'b1);
      // General random traffic.
      side = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 15) == 0) side = ~side;
         cycle(rtick(), side, ($urandom_range(0, 40) == 0) ? 1'b1 : 1'b0);
      end

      // Asynchronous reset in the middle of SIDE_GREEN with a pending pedestrian.
      hit = 1'b0;
      for (int i = 0; i < 400 && !hit; i++) begin
         cycle(rtick(), 1'b1, (m_ph == P_SG) ? 1'b1 : 1'b0);
         hit = (m_ph == P_SG) && m_ped && (m_el > 0);
      end
      chk("reach_side_green", int'(hit), 1);
      #2 rst_n = 1'b0;
      #1 model_reset();
      check_all();
      #1 rst_n = 1'b1;
      for (int i = 0; i < 30; i++) cycle(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(0, 10) == 0) side = ~side;
         cycle(rtick(), side, ($urandom_range(0, 20) == 0) ? 1'b1 : 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/intersection_scheduler.md
# intersection_scheduler

Phase scheduler for a two-approach intersection with a pedestrian crossing. It shares the junction between three requesters: the main road (default owner), the side road (vehicle sensor) and pedestrians (push button). It sequences green, yellow, all-red clearance and walk phases from a 1-tick-per-second strobe. It drives the per-approach light triplets and the countdown value consumed by the top-level 7-segment decoder.

## Interface
Parameters (all durations in ticks; legal range 1..15; T_MIN_GREEN <= T_MAX_GREEN):
- T_MIN_GREEN, 4, minimum green for either approach
- T_MAX_GREEN, 9, maximum side-road green
- T_YELLOW, 3, yellow duration
- T_CLEAR, 2, all-red clearance, also the post-reset hold
- T_WALK, 5, pedestrian walk duration

Ports:
- clk  in  1  single clock; all state changes on its rising edge
- rst_n  in  1  reset, asynchronous, active-low
- tick  in  1  one-cycle timing strobe; all phase timing counts ticks
- side_req  in  1  side-road vehicle present (level)
- ped_btn  in  1  pedestrian button, sampled every clk
- main_light  out  3  {green,yellow,red} for the main road
- side_light  out  3  {green,yellow,red} for the side road
- walk  out  1  pedestrian walk lamp
- remaining  out  4  ticks left in the current timed phase
- phase  out  3  current state code
- ped_pending  out  1  latched pedestrian request

## Operation
- States and phase codes:
  - INIT=0: all red.
  - MAIN_GREEN=1, MAIN_YELLOW=2, CLEAR_A=3: main green, main yellow, all red.
  - SIDE_GREEN=4, SIDE_YELLOW=5: side green, side yellow.
  - WALK=6: all vehicle red, walk=1.
  - CLEAR_B=7: all red.
- Tick counter `cnt` (4 bit) is cleared on every state change. It changes only on cycles with tick=1.
- Fixed-length states (INIT=T_CLEAR, MAIN_YELLOW/SIDE_YELLOW=T_YELLOW, CLEAR_A/CLEAR_B=T_CLEAR, WALK=T_WALK):
  - On tick with cnt==T-1, advance to the next state.
  - Otherwise, on tick, cnt+1.
- Fixed successors: INIT→MAIN_GREEN, MAIN_YELLOW→CLEAR_A, SIDE_YELLOW→CLEAR_B, WALK→CLEAR_B, CLEAR_B→MAIN_GREEN.
- MAIN_GREEN:
  - On tick with cnt>=T_MIN_GREEN-1 and (side_req or ped_pending): go to MAIN_YELLOW.
  - Otherwise, on tick, cnt saturates at T_MIN_GREEN-1.
  - With no request, main stays green indefinitely.
- SIDE_GREEN, evaluated on tick:
  - Leave to SIDE_YELLOW if cnt==T_MAX_GREEN-1.
  - Also leave if cnt>=T_MIN_GREEN-1 and side_req==0.
  - Otherwise cnt+1.
- CLEAR_A exit (arbitration uses the levels present on the exit cycle):
  - side_req only: go to SIDE_GREEN.
  - ped_pending only: go to WALK.
  - Both: go to the one not served last (`last_served`).
  - Neither: go to MAIN_GREEN.
- `last_served`: 0=side, 1=ped; reset value 1, so side wins the first tie. Set to 0 on entry to SIDE_GREEN and to 1 on entry to WALK.
- ped_pending:
  - Set by ped_btn=1 in any state except WALK; presses during WALK are ignored.
  - Cleared on the transition into WALK. Clear wins over a simultaneous press.
- remaining:
  - In timed states: T_state − cnt.
  - In SIDE_GREEN: T_MAX_GREEN − cnt.
  - In MAIN_GREEN: 0.
- Light encoding: bit0=red, bit1=yellow, bit2=green. Exactly one bit is set per triplet, and the two approaches are never green or yellow simultaneously.

## Timing
- Outputs are decoded combinationally from the registered state, cnt and ped_pending, so they are valid in the same cycle the state register updates.
- A state transition takes effect on the rising clk edge of the qualifying tick cycle.
- tick=0 cycles never change state or cnt. A ped_btn press is latched one cycle after sampling regardless of tick.
- Reset state (asserts immediately, independent of clk):
  - state=INIT, cnt=0, ped_pending=0, last_served=1.
  - Outputs: main_light=001, side_light=001, walk=0, phase=0, remaining=T_CLEAR.
- Reset deasserted mid-phase: restarts from INIT; no partial phase resumes.
- tick asserted on consecutive cycles: each cycle counts as one tick.

## Test plan
All values below use the default parameters.
- Reset, then 50 ticks with no requests → INIT for 2 ticks, then MAIN_GREEN held; main_light=100, side_light=001, remaining=0 throughout.
- side_req held high → phases in order: MAIN_GREEN 4 ticks, MAIN_YELLOW 3, CLEAR_A 2, SIDE_GREEN 9 (remaining 9..1), SIDE_YELLOW 3, CLEAR_B 2, then MAIN_GREEN. Sequence repeats.
- Single-cycle ped_btn pulse during MAIN_GREEN at tick 1 → ped_pending=1 next cycle. Sequence: MAIN_YELLOW at tick 4, CLEAR_A, then WALK with walk=1 and remaining 5..1. ped_pending=0 on WALK entry; a press during WALK leaves ped_pending=0.
- side_req and ped_pending both active at every CLEAR_A exit → first SIDE_GREEN, next cycle WALK, then SIDE_GREEN again (strict alternation).
- side_req drops 2 ticks into SIDE_GREEN → side green lasts exactly 4 ticks. Separately, side_req drops during CLEAR_A with no pedestrian request → next state MAIN_GREEN.
- rst_n pulsed low mid-SIDE_GREEN without a clk edge → outputs show all red, phase=0 and ped_pending=0 immediately. After release the INIT→MAIN_GREEN sequence restarts.
